// File: rtl/dual_fetch_if.sv
// Bundle between the dual-issue fetch buffer, instruction memory and the datapath.
// The fetch buffer uses the master modport; the memory/datapath side uses the slave modport.
interface dual_fetch_if #(
  parameter int ADDR_W = 32
);
  // Handshakes: mem_req is a one-cycle pulse and mem_rvalid answers it exactly one
  // cycle later. Slot N is offered whenever validN is high and is taken unless the
  // datapath holds it with freeze1 (both slots) or freeze2 (slot 1 only).
  logic              freeze1;
  logic              freeze2;
  logic              redirect_valid;
  logic [ADDR_W-1:0] redirect_pc;
  logic              mem_req;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_rvalid;
  logic [31:0]       mem_rdata0;
  logic [31:0]       mem_rdata1;
  logic [31:0]       instruction0;
  logic [31:0]       instruction1;
  logic              valid0;
  logic              valid1;
  logic [ADDR_W-1:0] pc0;

  modport master (
    input  freeze1, freeze2, redirect_valid, redirect_pc,
    input  mem_rvalid, mem_rdata0, mem_rdata1,
    output mem_req, mem_addr,
    output instruction0, instruction1, valid0, valid1, pc0
  );

  modport slave (
    output freeze1, freeze2, redirect_valid, redirect_pc,
    output mem_rvalid, mem_rdata0, mem_rdata1,
    input  mem_req, mem_addr,
    input  instruction0, instruction1, valid0, valid1, pc0
  );
endinterface

// File: rtl/dual_fetch_buffer.sv
// Circular instruction queue that fetches pairs from memory and offers up to two
// in-order instructions per cycle to a dual-issue datapath, with redirect flush.
module dual_fetch_buffer #(
  parameter int                DEPTH    = 8,
  parameter int                ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter logic [31:0]       NOP      = 32'h0000_0013
) (
  input logic          clk,
  input logic          rst,
  dual_fetch_if.master bus
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [31:0]       instr_mem [DEPTH];
  logic [ADDR_W-1:0] pc_mem    [DEPTH];

  logic [PTR_W-1:0]  head_q;
  logic [PTR_W-1:0]  tail_q;
  logic [PTR_W-1:0]  head_nxt;
  logic [PTR_W-1:0]  tail_nxt;
  logic [CNT_W-1:0]  count_q;
  logic [CNT_W-1:0]  count_d;
  logic [ADDR_W-1:0] fetch_pc_q;
  logic [ADDR_W-1:0] req_addr_q;
  logic              outstanding_q;
  logic              epoch_q;
  logic              req_epoch_q;

  logic              valid0;
  logic              valid1;
  logic              space_ok;
  logic              req;
  logic              push;
  logic [1:0]        pop_n;

  assign head_nxt = head_q + PTR_W'(1);
  assign tail_nxt = tail_q + PTR_W'(1);
  assign valid0   = (count_q != '0);
  assign valid1   = (count_q >= CNT_W'(2));

  always_comb begin
    pop_n = 2'd0;
    if (bus.freeze1) begin
      pop_n = 2'd0;
    end else if (bus.freeze2) begin
      pop_n = {1'b0, valid0};
    end else begin
      pop_n = {valid1, valid0 & ~valid1};
    end
  end

  // Room is checked before this cycle's pop, so the pair always fits on return.
  assign space_ok = (CNT_W'(DEPTH) - count_q) >= CNT_W'(2);
  assign req      = rst & ~bus.redirect_valid & ~outstanding_q & space_ok;
  assign push     = bus.mem_rvalid & outstanding_q & (req_epoch_q == epoch_q);
  assign count_d  = count_q + (push ? CNT_W'(2) : CNT_W'(0)) - CNT_W'(pop_n);

  assign bus.mem_req      = req;
  assign bus.mem_addr     = fetch_pc_q;
  assign bus.valid0       = valid0;
  assign bus.valid1       = valid1;
  assign bus.instruction0 = valid0 ? instr_mem[head_q]   : NOP;
  assign bus.instruction1 = valid1 ? instr_mem[head_nxt] : NOP;
  assign bus.pc0          = valid0 ? pc_mem[head_q]      : '0;

  always_ff @(posedge clk) begin
    if (!rst) begin
      head_q        <= '0;
      tail_q        <= '0;
      count_q       <= '0;
      fetch_pc_q    <= RESET_PC;
      req_addr_q    <= RESET_PC;
      outstanding_q <= 1'b0;
      epoch_q       <= 1'b0;
      req_epoch_q   <= 1'b0;
    end else if (bus.redirect_valid) begin
      // A response already in flight now carries the old epoch and is dropped.
      head_q        <= '0;
      tail_q        <= '0;
      count_q       <= '0;
      fetch_pc_q    <= {bus.redirect_pc[ADDR_W-1:2], 2'b00};
      outstanding_q <= 1'b0;
      epoch_q       <= ~epoch_q;
    end else begin
      head_q  <= head_q + PTR_W'(pop_n);
      count_q <= count_d;
      if (push) begin
        tail_q <= tail_q + PTR_W'(2);
      end
      if (bus.mem_rvalid) begin
        outstanding_q <= 1'b0;
      end
      if (req) begin
        outstanding_q <= 1'b1;
        req_epoch_q   <= epoch_q;
        req_addr_q    <= fetch_pc_q;
        fetch_pc_q    <= fetch_pc_q + ADDR_W'(8);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst && !bus.redirect_valid && push) begin
      instr_mem[tail_q]   <= bus.mem_rdata0;
      pc_mem[tail_q]      <= req_addr_q;
      instr_mem[tail_nxt] <= bus.mem_rdata1;
      pc_mem[tail_nxt]    <= req_addr_q + ADDR_W'(4);
    end
  end

endmodule
